// File: rtl/timer_apb_regs.sv
// -----------------------------------------------------------------------------
// timer_apb_regs
//
// APB slave register bank in front of the 8-bit timer counter stage. Holds the
// software-visible TDR (reload/compare data), TCR (control) and TSR (status)
// registers, feeds TDR/TCR/Clk_SEL to the counter, and turns the counter's
// over_flow/under_flow indications into sticky, write-0-to-clear status flags
// plus a combined interrupt.
//
// Register map (PADDR):
//   0x00 TDR  R/W [7:0]
//   0x01 TCR  R/W [7:0]   ([1:0] = Clk_SEL, [6] = OVF irq enable, [3] = UDF irq enable)
//   0x02 TSR  [0] OVF, [1] UDF, [7:2] read 0; writing 0 to a bit clears it
//   other     PSLVERR=1, writes ignored, PRDATA=0
//
// Ports:
//   PCLK, RST                      clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE,
//   PADDR[7:0], PWDATA[7:0]        APB request
//   PRDATA[7:0], PREADY, PSLVERR   APB response (all registered)
//   TDR[7:0], TCR[7:0], Clk_SEL    register outputs to the counter
//   over_flow, under_flow          counter events (level or pulse, PCLK domain)
//   irq                            (TSR[0] & TCR[6]) | (TSR[1] & TCR[3])
// -----------------------------------------------------------------------------
module timer_apb_regs #(
  parameter int unsigned WAIT_CYCLES = 0,      // PREADY-low access cycles, 0..7
  parameter logic [7:0]  TDR_RST     = 8'h00,
  parameter logic [7:0]  TCR_RST     = 8'h00
) (
  input  logic       PCLK,
  input  logic       RST,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic [7:0] TDR,
  output logic [7:0] TCR,
  output logic [1:0] Clk_SEL,
  input  logic       over_flow,
  input  logic       under_flow,
  output logic       irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_ACCESS
  } state_t;

  // Last wait-counter value before PREADY is raised (unused when WAIT_CYCLES=0).
  localparam logic [2:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [2:0]  r_wait_cnt;
  logic [7:0]  r_tdr;
  logic [7:0]  r_tcr;
  logic [1:0]  r_tsr;
  logic        r_ovf_prev;
  logic        r_udf_prev;

  logic        w_setup_phase;
  logic        w_sel_tdr;
  logic        w_sel_tcr;
  logic        w_sel_tsr;
  logic        w_addr_err;
  logic        w_enter_access;
  logic        w_commit;
  logic [7:0]  w_rd_data;
  logic [1:0]  w_tsr_clr;
  logic [1:0]  w_tsr_set;

  assign w_setup_phase = PSEL & ~PENABLE;
  assign w_sel_tdr     = (PADDR == 8'h00);
  assign w_sel_tcr     = (PADDR == 8'h01);
  assign w_sel_tsr     = (PADDR == 8'h02);
  assign w_addr_err    = ~(w_sel_tdr | w_sel_tcr | w_sel_tsr);

  // The setup phase is recognised on the edge that ends it, so with zero wait
  // states PREADY is already high in the first PENABLE cycle.
  assign w_enter_access =
      (((r_state == S_IDLE) || (r_state == S_SETUP)) && w_setup_phase && (WAIT_CYCLES == 0)) ||
      ((r_state == S_WAIT) && PSEL && (r_wait_cnt == WAIT_LAST));

  // Writes land on the edge that closes the PREADY=1 cycle; a dropped PSEL
  // in that cycle cancels the update.
  assign w_commit = (r_state == S_ACCESS) & PSEL & PENABLE & PWRITE;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_rd_data = 8'h00;
    if (w_sel_tdr)      w_rd_data = r_tdr;
    else if (w_sel_tcr) w_rd_data = r_tcr;
    else if (w_sel_tsr) w_rd_data = {6'b0, r_tsr};
  end

  // Rising-edge detect: a level held high sets its flag only once.
  assign w_tsr_set = {under_flow & ~r_udf_prev, over_flow & ~r_ovf_prev};
  // Write-0-to-clear; a set event on the same edge wins.
  assign w_tsr_clr = (w_commit && w_sel_tsr) ? ~PWDATA[1:0] : 2'b00;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE, S_SETUP: begin
          if (w_setup_phase) begin
            r_wait_cnt <= 3'd0;
            r_state    <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end else if (!PSEL) begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (!PSEL) begin
            r_state <= S_IDLE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state <= S_ACCESS;
          end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end
        end
        // PENABLE is still high here; a held PSEL means a back-to-back
        // transfer may present its setup phase next cycle.
        S_ACCESS: r_state <= PSEL ? S_SETUP : S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Response is captured on entry to ACCESS and held for exactly that cycle.
  always_ff @(posedge PCLK or negedge RST) begin
    if (!RST) begin
      PREADY  <= 1'b0;
      PRDATA  <= 8'h00;
      PSLVERR <= 1'b0;
    end else begin
      PREADY  <= w_enter_access;
      PRDATA  <= (w_enter_access && !PWRITE) ? w_rd_data : 8'h00;
      PSLVERR <= w_enter_access & w_addr_err;
    end
  end

  always_ff @(posedge PCLK or negedge RST) begin
    if (!RST) begin
      r_tdr      <= TDR_RST;
      r_tcr      <= TCR_RST;
      r_tsr      <= 2'b00;
      r_ovf_prev <= 1'b0;
      r_udf_prev <= 1'b0;
    end else begin
      if (w_commit && w_sel_tdr) r_tdr <= PWDATA;
      if (w_commit && w_sel_tcr) r_tcr <= PWDATA;
      r_tsr      <= w_tsr_set | (r_tsr & ~w_tsr_clr);
      r_ovf_prev <= over_flow;
      r_udf_prev <= under_flow;
    end
  end

  assign TDR     = r_tdr;
  assign TCR     = r_tcr;
  assign Clk_SEL = r_tcr[1:0];
  assign irq     = (r_tsr[0] & r_tcr[6]) | (r_tsr[1] & r_tcr[3]);

endmodule

// File: doc/timer_apb_regs.md
Name: timer_apb_regs

Overview:
APB slave register bank sitting directly upstream of the 8-bit timer counter stage (TCNT_sum). It holds the software-visible TDR (reload/compare data), TCR (control) and TSR (status) registers. It drives TDR, TCR and Clk_SEL into the counter. It consumes the counter's over_flow/under_flow outputs and converts them into sticky, software-clearable status flags plus a combined interrupt line.

Parameters:
WAIT_CYCLES, 0, number of wait states (PREADY low) inserted in the access phase of every transfer; legal range 0..7.
TDR_RST, 8'h00, reset value of TDR.
TCR_RST, 8'h00, reset value of TCR.

Ports:
PCLK  input  1  system clock; all state on rising edge.
RST  input  1  asynchronous, active-low reset (asserted when 0).
PSEL  input  1  APB select.
PENABLE  input  1  APB access phase.
PWRITE  input  1  1 = write, 0 = read.
PADDR  input  8  byte address.
PWDATA  input  8  write data.
PRDATA  output  8  read data, valid when PREADY=1 in access phase.
PREADY  output  1  transfer complete.
PSLVERR  output  1  error response, valid with PREADY=1.
TDR  output  8  timer data register to counter.
TCR  output  8  timer control register to counter.
Clk_SEL  output  2  TCR[1:0], clock-divider select to counter.
over_flow  input  1  counter overflow indication (level or pulse, PCLK domain).
under_flow  input  1  counter underflow indication (level or pulse, PCLK domain).
irq  output  1  interrupt: (TSR[0] & TCR[6]) | (TSR[1] & TCR[3]).

Behaviour:
- Reset is active-low and asynchronous, i.e. RST=0. All outputs and state reset immediately:
  - TDR=TDR_RST, TCR=TCR_RST, TSR=0.
  - PRDATA=0, PREADY=0, PSLVERR=0, irq=0.
  - Wait counter=0, FSM=IDLE, edge-detect registers=0.
- Register map, by PADDR:
  - 0x00 TDR: R/W, all 8 bits.
  - 0x01 TCR: R/W, all 8 bits.
  - 0x02 TSR: bit0 = OVF, bit1 = UDF, bits[7:2] read 0.
  - Any other address: PSLVERR=1, write ignored, PRDATA=0.
- FSM states: IDLE, SETUP, WAIT, ACCESS.
  - IDLE -> SETUP when PSEL=1 and PENABLE=0.
  - SETUP -> WAIT when PENABLE=1 and WAIT_CYCLES>0.
  - SETUP -> ACCESS when PENABLE=1 and WAIT_CYCLES=0.
  - WAIT counts WAIT_CYCLES cycles with PREADY=0, then goes to ACCESS.
  - ACCESS: PREADY=1 for exactly one cycle. Return to SETUP if PSEL=1 and PENABLE=0, else IDLE.
  - PSEL dropping mid-transfer returns the FSM to IDLE with no register update.
- Timing:
  - PREADY, PRDATA and PSLVERR are registered.
  - Zero-wait transfer completes in the second APB cycle (standard APB, PREADY high in the first PENABLE cycle).
  - Register write takes effect on the PCLK edge that ends the ACCESS cycle. New TDR/TCR are visible on outputs the following cycle.
  - Read data is sampled when entering ACCESS.
- TSR flag set:
  - Rising-edge detect on over_flow and under_flow: prev registers hold last-cycle values.
  - A set event is input=1 and prev=0. It sets TSR[0] or TSR[1] on that edge.
  - A level held high sets the flag only once.
- TSR flag clear:
  - A TSR write clears bit n when PWDATA[n]=0 and leaves it when PWDATA[n]=1. Writing 1 never sets a flag.
  - A set event and a clear in the same cycle: set wins and the flag stays 1.
- irq is combinational from registered TSR/TCR; no extra latency.
- Simultaneous over_flow and under_flow rising edges set both flags.
- Reset asserted mid-transfer aborts it. After release the FSM is in IDLE and the next transfer must start with a new SETUP phase.

Test Plan:
1. Reset: hold RST=0 20 ns, release -> TDR=0x00, TCR=0x00, Clk_SEL=0, TSR read=0x00, PREADY=0, irq=0.
2. Write TDR=0xDF, then TCR=0x90, WAIT_CYCLES=0 -> each transfer PREADY=1 on first PENABLE cycle. Read back 0xDF and 0x90. Clk_SEL=2'b00. Then write TCR=0x91 -> Clk_SEL=2'b01 the next cycle.
3. WAIT_CYCLES=3, read TDR -> PREADY low 3 access cycles, high on the 4th, PRDATA=0xDF.
4. Pulse over_flow 1 cycle; hold under_flow high 10 cycles -> TSR=0x03 (UDF set once). With TCR=0x40, irq=1. Write TSR=0x02 -> TSR=0x02, irq=0.
5. over_flow rising edge in the same cycle as a TSR write of 0x00 -> TSR[0]=1 afterwards; TSR[1] cleared.
6. Access to PADDR=0x05: write 0xFF then read -> PSLVERR=1 both times, PRDATA=0, TDR/TCR/TSR unchanged. Assert RST=0 during a WAIT_CYCLES=3 write -> write discarded, registers at reset values.
